// File: rtl/smc_trans_sched.sv
// smc_trans_sched: sequences SCCB transactions from the register-map FIFOs into byte commands for the PHY,
// with a per-phase watchdog that aborts the bus and drains the aborted command's leftover FIFO entries.
module smc_trans_sched #(
    parameter int                   DATA_W      = 8,
    parameter int                   TIMEOUT_W   = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-2:0] i_slv_dvc_addr,
    input  logic [1:0]        i_phase_amt,
    input  logic              i_trans_type,
    input  logic              i_ctrl_vld,
    output logic              o_ctrl_rdy,
    input  logic [DATA_W-1:0] i_tx_sub_adr,
    input  logic              i_tx_sub_adr_vld,
    output logic              o_tx_sub_adr_rdy,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_data_vld,
    output logic              o_tx_data_rdy,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_vld,
    input  logic              i_rx_rdy,
    output logic [DATA_W-1:0] o_cmd_byte,
    output logic              o_cmd_start,
    output logic              o_cmd_stop,
    output logic              o_cmd_rd,
    output logic              o_cmd_vld,
    input  logic              i_cmd_rdy,
    input  logic              i_phy_done,
    input  logic [DATA_W-1:0] i_phy_rd_data,
    output logic              o_phy_abort,
    output logic              o_busy,
    output logic              o_err,
    input  logic              i_err_clr
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_ID_ISS  = 4'd1;
    localparam logic [3:0] S_ID_WT   = 4'd2;
    localparam logic [3:0] S_SUB_ISS = 4'd3;
    localparam logic [3:0] S_SUB_WT  = 4'd4;
    localparam logic [3:0] S_DAT_ISS = 4'd5;
    localparam logic [3:0] S_DAT_WT  = 4'd6;
    localparam logic [3:0] S_RD_ISS  = 4'd7;
    localparam logic [3:0] S_RD_WT   = 4'd8;
    localparam logic [3:0] S_RX_PUSH = 4'd9;
    localparam logic [3:0] S_DRAIN   = 4'd10;
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_CYC - 1'b1;

    logic [3:0]           r_state, w_nxt;
    logic [TIMEOUT_W-1:0] r_wd;
    logic                 r_wr, r_rd, r_err;
    logic [1:0]           r_drain, w_drain_init;
    logic [DATA_W-1:0]    r_rx_data;
    logic w_idle, w_wt, w_done, w_to, w_err_hold, w_ctrl_pop, w_legal, w_hs;
    logic w_drain_act, w_drain_sub, w_drain_pop;

    assign w_idle      = r_state == S_IDLE;
    assign w_wt        = r_state == S_ID_WT || r_state == S_SUB_WT || r_state == S_DAT_WT || r_state == S_RD_WT;
    assign w_done      = w_wt && i_phy_done;
    assign w_to        = w_wt && !i_phy_done && r_wd == TO_LAST;
    assign w_err_hold  = r_err && !i_err_clr;
    assign w_ctrl_pop  = !rst && w_idle && !w_err_hold && i_ctrl_vld;
    assign w_legal     = i_phase_amt == 2'd2 || (!i_trans_type && i_phase_amt == 2'd3);
    assign w_hs        = o_cmd_vld && i_cmd_rdy;
    // Leftover entries drain sub-address first: two left means sub+data, one left is a sub only for address-set.
    assign w_drain_act = !rst && r_state == S_DRAIN && r_drain != 2'd0;
    assign w_drain_sub = r_drain == 2'd2 || (r_drain == 2'd1 && !r_wr);
    assign w_drain_pop = w_drain_act && (w_drain_sub ? i_tx_sub_adr_vld : i_tx_data_vld);
    assign w_drain_init = r_state == S_ID_WT ? (r_wr ? 2'd2 : r_rd ? 2'd0 : 2'd1) :
                          (r_state == S_SUB_WT && r_wr) ? 2'd1 : 2'd0;

    assign o_ctrl_rdy       = !rst && w_idle && !w_err_hold;
    assign o_cmd_vld        = !rst && (r_state == S_ID_ISS || r_state == S_RD_ISS ||
                              (r_state == S_SUB_ISS && i_tx_sub_adr_vld) ||
                              (r_state == S_DAT_ISS && i_tx_data_vld));
    assign o_tx_sub_adr_rdy = !rst && ((r_state == S_SUB_ISS && i_cmd_rdy) || (w_drain_act && w_drain_sub && i_tx_sub_adr_vld));
    assign o_tx_data_rdy    = !rst && ((r_state == S_DAT_ISS && i_cmd_rdy) || (w_drain_act && !w_drain_sub && i_tx_data_vld));
    assign o_cmd_byte       = rst ? '0 :
                              r_state == S_ID_ISS  ? {i_slv_dvc_addr, r_rd} :
                              r_state == S_SUB_ISS ? i_tx_sub_adr :
                              r_state == S_DAT_ISS ? i_tx_data : '0;
    assign o_cmd_start      = !rst && r_state == S_ID_ISS;
    assign o_cmd_stop       = !rst && ((r_state == S_SUB_ISS && !r_wr) || r_state == S_DAT_ISS || r_state == S_RD_ISS);
    assign o_cmd_rd         = !rst && r_state == S_RD_ISS;
    assign o_rx_vld         = !rst && r_state == S_RX_PUSH;
    assign o_rx_data        = o_rx_vld ? r_rx_data : '0;
    assign o_phy_abort      = !rst && w_to;
    assign o_busy           = !rst && !w_idle;
    assign o_err            = !rst && r_err;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:    w_nxt = (w_ctrl_pop && w_legal) ? S_ID_ISS : S_IDLE;
            S_ID_ISS:  w_nxt = w_hs ? S_ID_WT : r_state;
            S_ID_WT:   w_nxt = w_done ? (r_rd ? S_RD_ISS : S_SUB_ISS) : w_to ? S_DRAIN : r_state;
            S_SUB_ISS: w_nxt = w_hs ? S_SUB_WT : r_state;
            S_SUB_WT:  w_nxt = w_done ? (r_wr ? S_DAT_ISS : S_IDLE) : w_to ? S_DRAIN : r_state;
            S_DAT_ISS: w_nxt = w_hs ? S_DAT_WT : r_state;
            S_DAT_WT:  w_nxt = w_done ? S_IDLE : w_to ? S_DRAIN : r_state;
            S_RD_ISS:  w_nxt = w_hs ? S_RD_WT : r_state;
            S_RD_WT:   w_nxt = w_done ? S_RX_PUSH : w_to ? S_DRAIN : r_state;
            S_RX_PUSH: w_nxt = i_rx_rdy ? S_IDLE : r_state;
            S_DRAIN:   w_nxt = (r_drain == 2'd0 || (w_drain_pop && r_drain == 2'd1)) ? S_IDLE : r_state;
            default:   w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wd      <= '0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_drain   <= 2'd0;
            r_rx_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_wd    <= w_wt ? r_wd + 1'b1 : '0;
            if (w_ctrl_pop) begin
                r_wr <= !i_trans_type && i_phase_amt == 2'd3;
                r_rd <= i_trans_type;
            end
            if (w_to)
                r_drain <= w_drain_init;
            else if (w_drain_pop)
                r_drain <= r_drain - 2'd1;
            if (r_state == S_RD_WT && i_phy_done)
                r_rx_data <= i_phy_rd_data;
            r_err <= (w_ctrl_pop && !w_legal) || w_to || w_err_hold;
        end
    end
endmodule
